// File: rtl/tns_decoder_19.sv
// Iterative TNS decoder: accumulates one 3-bit group of codeword weights per cycle.
// Define TNS_DEC_ERR_EN to add the dec_err_o overflow flag.
`ifndef BLEN07_C
// Fallback weight set (tribonacci), normally supplied by TNS.vh.
`define BLEN07_C 17
`define TNS07_C  66012
`define TNS06_A  35890
`define TNS06_B  19513
`define TNS06_C  10609
`define TNS05_A  5768
`define TNS05_B  3136
`define TNS05_C  1705
`define TNS04_A  927
`define TNS04_B  504
`define TNS04_C  274
`define TNS03_A  149
`define TNS03_B  81
`define TNS03_C  44
`define TNS02_A  24
`define TNS02_B  13
`define TNS02_C  7
`define TNS01_A  4
`define TNS01_B  2
`define TNS01_C  1
`endif

module tns_decoder_19 (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [18:0]          codein_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [`BLEN07_C-1:0] dataout_o,
    output logic                 out_valid_o,
`ifdef TNS_DEC_ERR_EN
    output logic                 dec_err_o,
`endif
    input  logic                 out_ready_i
);

    localparam int DW = `BLEN07_C;
    localparam int AW = DW + 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [18:0]     cw_q, cw_d;
    logic [2:0]      grp_q, grp_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            err_q, err_d;

    logic [AW-1:0]   wa, wb, wc, grp_sum;
    logic [4:0]      base;
    logic [18:0]     sh;

    always_comb begin
        wa = '0;
        wb = '0;
        wc = '0;
        case (grp_q)
            3'd6: begin wa = AW'(`TNS06_A); wb = AW'(`TNS06_B); wc = AW'(`TNS06_C); end
            3'd5: begin wa = AW'(`TNS05_A); wb = AW'(`TNS05_B); wc = AW'(`TNS05_C); end
            3'd4: begin wa = AW'(`TNS04_A); wb = AW'(`TNS04_B); wc = AW'(`TNS04_C); end
            3'd3: begin wa = AW'(`TNS03_A); wb = AW'(`TNS03_B); wc = AW'(`TNS03_C); end
            3'd2: begin wa = AW'(`TNS02_A); wb = AW'(`TNS02_B); wc = AW'(`TNS02_C); end
            3'd1: begin wa = AW'(`TNS01_A); wb = AW'(`TNS01_B); wc = AW'(1);        end
            default: ;
        endcase
    end

    // Group grp occupies bits 3grp-1..3grp-3; shift it down to [2:0].
    assign base    = {2'b00, grp_q} * 5'd3;
    assign sh      = cw_q >> (base - 5'd3);
    assign grp_sum = (sh[2] ? wa : '0) + (sh[1] ? wb : '0) + (sh[0] ? wc : '0);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cw_d       = cw_q;
        grp_d      = grp_q;
        dout_d     = dout_q;
        err_d      = err_q;
        in_ready_o = 1'b0;
        case (state_q)
            IDLE: in_ready_o = 1'b1;
            ACC: begin
                acc_d = acc_q + grp_sum;
                grp_d = grp_q - 3'd1;
                if (grp_q == 3'd1) begin
                    state_d = DONE;
                    dout_d  = acc_d[DW-1:0];
                    err_d   = acc_d[DW];
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    in_ready_o = 1'b1;
                    err_d      = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A load in DONE overlaps the transfer of the finished word.
        if (in_ready_o && in_valid_i) begin
            cw_d    = codein_i;
            acc_d   = codein_i[18] ? AW'(`TNS07_C) : '0;
            grp_d   = 3'd6;
            state_d = ACC;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cw_q    <= '0;
            grp_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cw_q    <= cw_d;
            grp_q   <= grp_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign dataout_o   = dout_q;
    assign out_valid_o = (state_q == DONE);

`ifdef TNS_DEC_ERR_EN
    assign dec_err_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_tns_decoder_19.sv
// Directed bench for tns_decoder_19: single-bit weights, round trip, backpressure, reset.
`ifndef BLEN07_C
`define BLEN07_C 17
`define TNS07_C  66012
`define TNS06_A  35890
`define TNS06_B  19513
`define TNS06_C  10609
`define TNS05_A  5768
`define TNS05_B  3136
`define TNS05_C  1705
`define TNS04_A  927
`define TNS04_B  504
`define TNS04_C  274
`define TNS03_A  149
`define TNS03_B  81
`define TNS03_C  44
`define TNS02_A  24
`define TNS02_B  13
`define TNS02_C  7
`define TNS01_A  4
`define TNS01_B  2
`define TNS01_C  1
`endif

module tb_tns_decoder_19;
    localparam int DW = `BLEN07_C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [18:0]   codein = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] dataout;
`ifdef TNS_DEC_ERR_EN
    logic          dec_err;
`endif

    int checks = 0;
    int errors = 0;
    int unsigned w [19];

    tns_decoder_19 dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .codein_i   (codein),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .dataout_o  (dataout),
        .out_valid_o(out_valid),
`ifdef TNS_DEC_ERR_EN
        .dec_err_o  (dec_err),
`endif
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] encode(input int unsigned d);
        int unsigned rem = d;
        logic [18:0] cw = '0;
        for (int i = 18; i >= 0; i--) begin
            if (rem >= w[i]) begin
                cw[i] = 1'b1;
                rem   = rem - w[i];
            end
        end
        return cw;
    endfunction

    // Offer cw; returns #1 after the accepting edge.
    task automatic send(input logic [18:0] cw);
        int n = 0;
        @(negedge clk);
        codein   = cw;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic run(input logic [18:0] cw, input logic [DW-1:0] exp, input logic exp_err,
                       input string tag);
        int n;
        send(cw);
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'd6);
        chk({tag, "_data"}, 32'(dataout), 32'(exp));
`ifdef TNS_DEC_ERR_EN
        chk({tag, "_err"}, 32'(dec_err), 32'(exp_err));
`else
        if (exp_err) n = 0;
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int unsigned d;
        w[18] = `TNS07_C;
        w[17] = `TNS06_A; w[16] = `TNS06_B; w[15] = `TNS06_C;
        w[14] = `TNS05_A; w[13] = `TNS05_B; w[12] = `TNS05_C;
        w[11] = `TNS04_A; w[10] = `TNS04_B; w[9]  = `TNS04_C;
        w[8]  = `TNS03_A; w[7]  = `TNS03_B; w[6]  = `TNS03_C;
        w[5]  = `TNS02_A; w[4]  = `TNS02_B; w[3]  = `TNS02_C;
        w[2]  = `TNS01_A; w[1]  = `TNS01_B; w[0]  = 1;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dataout", 32'(dataout), 32'd0);
`ifdef TNS_DEC_ERR_EN
        chk("rst_dec_err", 32'(dec_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run(19'h00000, '0, 1'b0, "zero");
        chk("idle_ready", 32'(in_ready), 32'd1);

        // Each single bit returns its own weight
        for (int i = 0; i < 19; i++)
            run(19'(1) << i, DW'(w[i]), 1'b0, $sformatf("bit%0d", i));

        // Round trip through a greedy encoder; 121414 is the largest encodable word
        for (int k = 0; k < 1000; k++) begin
            d = $urandom_range(0, 121414);
            run(encode(d), DW'(d), 1'b0, "rt");
        end

        // Backpressure: DONE held with a pending input
        send(19'h00020);
        wait_valid(n);
        chk("bp_lat", 32'(n), 32'd6);
        @(negedge clk);
        codein   = 19'h00008;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_data", 32'(dataout), 32'd24);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_ready_hi", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_xfer", 32'(out_valid), 32'd0);
        wait_valid(n);
        chk("bp2_lat", 32'(n), 32'd6);
        chk("bp2_data", 32'(dataout), 32'd7);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset mid-accumulation discards the word
        send(19'h40000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(dataout), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("mid_rst_quiet", 32'(out_valid), 32'd0);
        end
        run(19'h40001, DW'(66013), 1'b0, "post_rst");

        // All-ones: total weight 144663 truncates to 13591 and overflows bit 17
        run(19'h7FFFF, DW'(13591), 1'b1, "all_ones");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
